traffic_light_monitor: RTL
==========================

// Module: traffic_light_monitor
// PURPOSE
//  Receiving end of the six-lamp interface driven by the traffic light controller (R/Y/G, bit1=primary, bit0=secondary).
//  Samples lamps every Clock, decodes them to a phase, checks sequencing and dwell timing, raises sticky faults.
//  Sits beside the controller as a safety/conformance watchdog; purely observational, never drives lamps.
// PARAMETERS
//  CNT_W      8   width of dwell counter and cycle counter
//  MIN_YELLOW 2   minimum legal cycles in a yellow phase (P1, P3)
//  MAX_DWELL  64  maximum legal cycles in any non-flash phase; must be < 2**CNT_W
// PORTS
//  Clock      in   1      single clock; all state updates on posedge
//  Reset      in   1      synchronous, active-high
//  R          in   2      red lamps {primary,secondary}
//  Y          in   2      yellow lamps
//  G          in   2      green lamps
//  Phase      out  3      decoded phase of last sample (encoding in package)
//  PhaseDone  out  1      1-cycle pulse: phase changed on last sample
//  Dwell      out  CNT_W  cycles spent in current phase, saturating
//  Cycles     out  CNT_W  completed P0->P3->P0 cycles, wraps at 2**CNT_W
//  Fault      out  1      sticky fault flag
//  FaultCode  out  3      code of first fault; 0 when Fault=0
// BEHAVIOUR
//  Reset: Phase=ALLRED, PhaseDone=0, Dwell=0, Cycles=0, Fault=0, FaultCode=0; Reset dominates all events.
//  Decode {R,Y,G}: P0 PG+SR; P1 PY+SR; P2 PR+SG; P3 PR+SY; ALLRED PR+SR; FLASH_ON PY+SR w/ Y[0]=0,
//   i.e. FLASH_ON = R=01,Y=10,G=00 only when flash tracked (see FSM); DARK all lamps off; anything else ILLEGAL.
//  FSM states = phases {ALLRED,P0,P1,P2,P3,FLASH,DARK}; registered, 1-cycle latency sample->Phase/Fault.
//  Legal transitions: ALLRED->P0|P2; P0->P1; P1->ALLRED|P2; P2->P3; P3->ALLRED|P0; any->DARK;
//   DARK<->FLASH alternate; DARK/FLASH->ALLRED|P0 exits flash. Same-phase repeat is always legal.
//  While FSM in DARK/FLASH, pattern R=01,Y=10,G=00 decodes as FLASH, not P1.
//  Dwell: cleared to 1 on phase change, else +1, saturates at all-ones.
//  Cycles: +1 on P3->P0 or P3->ALLRED->P0 completion (count on entering P0 from P3 or ALLRED-after-P3).
//  Fault codes (check each sample; lowest code wins if several same cycle):
//   1 G==2'b11 conflicting greens; 2 >1 lamp lit in one direction; 3 other ILLEGAL pattern;
//   4 illegal transition; 5 leaving P1/P3 with Dwell<MIN_YELLOW; 6 Dwell reaches MAX_DWELL in P0..P3/ALLRED.
//  Fault sets next cycle, stays until Reset; FaultCode latches first code only; later faults ignored.
//  On ILLEGAL sample FSM holds previous phase; Dwell keeps counting.
//  FLASH/DARK exempt from MAX_DWELL and MIN_YELLOW.
// CONFIGURATION
//  TLM_HISTORY_EN defined: extra output PhaseHist[11:0] = last 4 distinct phases, [2:0] newest,
//   shifts on PhaseDone, reset to 4x ALLRED.
//  Not defined: port absent, no history storage; all other behaviour identical.
// STRUCTURE
//  Package tlm_pkg: phase_t enum (ALLRED=0,P0=1,P1=2,P2=3,P3=4,FLASH=5,DARK=6), fault code
//   constants FLT_NONE..FLT_MAXDWELL, lamp-pattern constants, legal-transition function.
//  One sub-module: tlm_sat_counter (CNT_W, clear-to-1/increment/saturate), used for Dwell.
// TESTING
//  Reset, then P0x5,P1x2,P2x5,P3x2,P0 -> Phase follows 1 cycle late, Cycles=1, Fault=0.
//  G=11 for 1 sample mid-P0 -> Fault=1, FaultCode=1 next cycle, sticky after lamps recover.
//  P0x5 then P1x1 then P2 -> FaultCode=5; same with P1x2 -> no fault.
//  P0 directly to P2 -> FaultCode=4; P0 held 64 cycles -> FaultCode=6 when Dwell=64.
//  Alternate DARK/FLASH 200 cycles then ALLRED,P0 -> no fault, Phase=FLASH/DARK toggling, Cycles unchanged.
//  G=11 and Y=11 same sample -> FaultCode=1; Reset asserted with fault pending -> all outputs reset values.

Source files
------------

// File: rtl/tlm_pkg.sv
// Shared types, lamp patterns, fault codes and transition rules for the traffic light monitor.
package tlm_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    P0     = 3'd1,
    P1     = 3'd2,
    P2     = 3'd3,
    P3     = 3'd4,
    FLASH  = 3'd5,
    DARK   = 3'd6
  } phase_t;

  typedef struct packed {
    logic   ok;
    phase_t ph;
  } dec_t;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_GREENS   = 3'd1;
  localparam logic [2:0] FLT_MULTI    = 3'd2;
  localparam logic [2:0] FLT_ILLEGAL  = 3'd3;
  localparam logic [2:0] FLT_TRANS    = 3'd4;
  localparam logic [2:0] FLT_MINYEL   = 3'd5;
  localparam logic [2:0] FLT_MAXDWELL = 3'd6;

  // Lamp patterns as {R,Y,G}, each field {primary,secondary}
  localparam logic [5:0] PAT_ALLRED = 6'b11_00_00;
  localparam logic [5:0] PAT_P0     = 6'b01_00_10;
  localparam logic [5:0] PAT_P1     = 6'b01_10_00;
  localparam logic [5:0] PAT_P2     = 6'b10_00_01;
  localparam logic [5:0] PAT_P3     = 6'b10_01_00;
  localparam logic [5:0] PAT_DARK   = 6'b00_00_00;

  // The P1 pattern means FLASH once the controller has gone dark
  function automatic dec_t decode(input logic [5:0] lamps, input logic flashing);
    dec_t d;
    d.ok = 1'b1;
    d.ph = ALLRED;
    case (lamps)
      PAT_ALLRED: d.ph = ALLRED;
      PAT_P0:     d.ph = P0;
      PAT_P1:     d.ph = flashing ? FLASH : P1;
      PAT_P2:     d.ph = P2;
      PAT_P3:     d.ph = P3;
      PAT_DARK:   d.ph = DARK;
      default:    d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic legal(input phase_t from, input phase_t to);
    if (from == to || to == DARK) return 1'b1;
    case (from)
      ALLRED:  return to inside {P0, P2};
      P0:      return to == P1;
      P1:      return to inside {ALLRED, P2};
      P2:      return to == P3;
      P3:      return to inside {ALLRED, P0};
      DARK:    return to inside {FLASH, ALLRED, P0};
      FLASH:   return to inside {ALLRED, P0};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic timed(input phase_t ph);
    return ph inside {ALLRED, P0, P1, P2, P3};
  endfunction

endpackage

// File: rtl/tlm_sat_counter.sv
// Saturating counter: loads 1 on clr, otherwise increments and sticks at all-ones.
module tlm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] nxt,
  output logic [W-1:0] cnt
);

  always_comb begin
    nxt = cnt;
    if (clr)       nxt = W'(1);
    else if (~&cnt) nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observes six-lamp controller outputs, tracks phase/dwell/cycles and latches the first fault.
// Define TLM_HISTORY_EN to add the PhaseHist output (last 4 distinct phases).
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       R,
  input  logic [1:0]       Y,
  input  logic [1:0]       G,
  output logic [2:0]       Phase,
  output logic             PhaseDone,
  output logic [CNT_W-1:0] Dwell,
  output logic [CNT_W-1:0] Cycles,
  output logic             Fault,
  output logic [2:0]       FaultCode
`ifdef TLM_HISTORY_EN
  ,
  output logic [11:0]      PhaseHist
`endif
);

  localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);

  phase_t           state, nxt;
  dec_t             dec;
  logic             change, multi, after_p3;
  logic [2:0]       code;
  logic [CNT_W-1:0] dwell_nxt;

  always_comb begin
    dec    = decode({R, Y, G}, state inside {DARK, FLASH});
    nxt    = dec.ok ? dec.ph : state;
    change = nxt != state;
    multi  = ((R[1] & Y[1]) | (R[1] & G[1]) | (Y[1] & G[1])) |
             ((R[0] & Y[0]) | (R[0] & G[0]) | (Y[0] & G[0]));
    code   = FLT_NONE;
    if (G == 2'b11)                 code = FLT_GREENS;
    else if (multi)                 code = FLT_MULTI;
    else if (!dec.ok)               code = FLT_ILLEGAL;
    else if (!legal(state, nxt))    code = FLT_TRANS;
    else if (change && state inside {P1, P3} && Dwell < MIN_Y)
                                    code = FLT_MINYEL;
    else if (timed(nxt) && dwell_nxt >= MAX_D)
                                    code = FLT_MAXDWELL;
  end

  tlm_sat_counter #(.W(CNT_W)) u_dwell (
    .clk (Clock),
    .rst (Reset),
    .clr (change),
    .nxt (dwell_nxt),
    .cnt (Dwell)
  );

  // after_p3 remembers that the current ALLRED was entered from P3, so ALLRED->P0 closes a cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ALLRED;
      PhaseDone <= 1'b0;
      Cycles    <= '0;
      Fault     <= 1'b0;
      FaultCode <= FLT_NONE;
      after_p3  <= 1'b0;
    end else begin
      state     <= nxt;
      PhaseDone <= change;
      if (change) after_p3 <= (state == P3) && (nxt == ALLRED);
      if (change && nxt == P0 && (state == P3 || (state == ALLRED && after_p3)))
        Cycles <= Cycles + 1'b1;
      if (!Fault && code != FLT_NONE) begin
        Fault     <= 1'b1;
        FaultCode <= code;
      end
    end
  end

  assign Phase = state;

`ifdef TLM_HISTORY_EN
  always_ff @(posedge Clock) begin
    if (Reset)       PhaseHist <= {4{3'(ALLRED)}};
    else if (change) PhaseHist <= {PhaseHist[8:0], 3'(nxt)};
  end
`endif

endmodule
